bounce_gen: RTL
===============

BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter BOUNCES_MAX, default 8: ceiling on bounce pairs per transition, legal range 1..15.
REQ-002 SHALL have parameter GLITCH_W, default 8: each bounce phase lasts 1..2^GLITCH_W cycles, legal range 1..16.
REQ-003 SHALL have parameter HOLD_CYCLES, default 1000: stable cycles after the final toggle before done, minimum 1.
REQ-004 SHALL have parameter SEED, default 16'hACE1: LFSR reset value; SEED=0 SHALL be replaced by 16'h0001.
REQ-005 SHALL have parameter RESET_LEVEL, default 1'b0: sw_out value during and after reset.
REQ-006 clk  input  1  clock, all state updates on rising edge.
REQ-007 reset  input  1  reset, asynchronous, active-high.
REQ-008 start  input  1  transition request, sampled only in IDLE.
REQ-009 level_in  input  1  target settled level for the requested transition.
REQ-010 num_bounces  input  4  requested bounce pairs; values above BOUNCES_MAX are clipped to BOUNCES_MAX.
REQ-011 sw_out  output  1  emulated mechanical switch level, registered; feeds a debounce sw input.
REQ-012 busy  output  1  high while a transition is in progress, registered.
REQ-013 done  output  1  one-cycle pulse at completion, registered.

Function
REQ-014 SHALL implement FSM states IDLE, BOUNCE, HOLD.
REQ-015 SHALL run a 16-bit Galois LFSR (mask 16'hB400) that advances every clock cycle regardless of state.
- The phase duration d SHALL be LFSR[GLITCH_W-1:0]+1.
- d SHALL be computed in GLITCH_W+1 bits so that no wrap to 0 occurs.
REQ-016 IDLE, start=1, level_in!=sw_out:
- At the next edge: sw_out toggles, busy=1, target is latched, and k=min(num_bounces,BOUNCES_MAX) is latched.
- If k=0: go to HOLD with the timer at HOLD_CYCLES.
- Else: go to BOUNCE with remaining toggles 2k and phase timer d.
REQ-017 BOUNCE:
- sw_out SHALL hold each level for exactly d cycles, then toggle and reload d.
- Remaining toggles decrement on each toggle.
- The toggle that makes remaining=0 SHALL leave sw_out=target and enter HOLD with the timer at HOLD_CYCLES.
REQ-018 Total toggles per transition SHALL be exactly 2k+1, with the final level = target.
REQ-019 HOLD: sw_out SHALL remain at target for exactly HOLD_CYCLES cycles; at the edge ending HOLD: state=IDLE, busy=0, done=1 for one cycle.
REQ-020 IDLE, start=1, level_in==sw_out: no toggle, busy stays 0, done=1 on the next cycle only.
REQ-021 start while busy=1 SHALL be ignored, with no queuing; level_in and num_bounces SHALL be ignored after latching.
REQ-022 start held high in IDLE SHALL begin a new transition on each IDLE cycle it is sampled, including the cycle after done.
REQ-023 The HOLD counter width SHALL be $clog2(HOLD_CYCLES+1); no counter SHALL wrap below zero.

Reset
REQ-024 Reset asserted SHALL immediately force: state=IDLE, sw_out=RESET_LEVEL, busy=0, done=0, LFSR=SEED (or 1), all timers and counters=0.
REQ-025 Reset mid-BOUNCE or mid-HOLD SHALL abort the transition without a done pulse; after release the block SHALL be idle and accept start on the first clock.

Verification
REQ-026 Reset, RESET_LEVEL=0, HOLD_CYCLES=16, start=1 for one cycle at T with level_in=1, num_bounces=0 -> sw_out=1 and busy=1 from T+1; done=1 only at T+17 with busy=0; sw_out never toggles again.
REQ-027 level_in=0 from sw_out=1, num_bounces=3 -> exactly 7 toggles on sw_out; every phase length in 1..256; final sw_out=0 held 16 cycles before done; single done pulse.
REQ-028 num_bounces=15, BOUNCES_MAX=8 -> exactly 17 toggles, ending at target.
REQ-029 start with level_in==sw_out=1 -> no sw_out change, busy stays 0, done pulse the next cycle; a second start pulse during busy -> no effect on toggle count or timing.
REQ-030 Reset asserted mid-BOUNCE -> sw_out=RESET_LEVEL, busy=0, done=0 immediately; no done later; a new start completes normally.
REQ-031 Two runs with SEED=16'hACE1 and identical stimulus -> identical sw_out traces; SEED=0 -> the LFSR is never stuck at 0, with phase lengths still in range.

Source files
------------

// File: rtl/bounce_gen_if.sv
// Bus between a stimulus source and bounce_gen: transition request in, emulated switch level and status out.
// start is a level-sampled request with no ready: it is taken only on a clock where the block is idle, otherwise dropped.
interface bounce_gen_if;
    logic       start;
    logic       level_in;
    logic [3:0] num_bounces;
    logic       sw_out;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    modport master (
        output start, level_in, num_bounces,
        input  sw_out, busy, done, state_dbg
    );

    modport slave (
        input  start, level_in, num_bounces,
        output sw_out, busy, done, state_dbg
    );
endinterface

// File: rtl/bounce_gen.sv
// Mechanical switch emulator: on request, drives sw_out to a new level with pseudo-random bounce
// toggles, holds it stable for HOLD_CYCLES, then pulses done.
module bounce_gen #(
    parameter int unsigned BOUNCES_MAX = 8,
    parameter int unsigned GLITCH_W    = 8,
    parameter int unsigned HOLD_CYCLES = 1000,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    bounce_gen_if.slave  bus
);
    localparam int unsigned HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned PH_W      = GLITCH_W + 1;
    localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  K_MAX     = 4'(BOUNCES_MAX);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BOUNCE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sw_q, sw_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              target_q, target_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [4:0]        remain_q, remain_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [PH_W-1:0]   phase_len;
    logic [3:0]        k_clip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sw_q     <= RESET_LEVEL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            target_q <= RESET_LEVEL;
            lfsr_q   <= LFSR_INIT;
            remain_q <= '0;
            phase_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            target_q <= target_d;
            lfsr_q   <= lfsr_d;
            remain_q <= remain_d;
            phase_q  <= phase_d;
            hold_q   <= hold_d;
        end
    end

    // Extra width on the phase length keeps an all-ones LFSR slice from wrapping to zero.
    always_comb begin
        lfsr_d    = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
        phase_len = {1'b0, lfsr_q[GLITCH_W-1:0]} + PH_W'(1);
        k_clip    = (bus.num_bounces > K_MAX) ? K_MAX : bus.num_bounces;
    end

    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        target_d = target_q;
        remain_d = remain_q;
        phase_d  = phase_q;
        hold_d   = hold_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.level_in != sw_q) begin
                        sw_d     = ~sw_q;
                        busy_d   = 1'b1;
                        target_d = bus.level_in;
                        if (k_clip == 4'd0) begin
                            state_d = S_HOLD;
                            hold_d  = HOLD_LOAD;
                        end else begin
                            state_d  = S_BOUNCE;
                            remain_d = {k_clip, 1'b0};
                            phase_d  = phase_len;
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_BOUNCE: begin
                if (phase_q > PH_W'(1)) begin
                    phase_d = phase_q - PH_W'(1);
                end else if (remain_q <= 5'd1) begin
                    // Last bounce toggle lands on the latched target.
                    sw_d     = target_q;
                    remain_d = '0;
                    phase_d  = '0;
                    state_d  = S_HOLD;
                    hold_d   = HOLD_LOAD;
                end else begin
                    sw_d     = ~sw_q;
                    remain_d = remain_q - 5'd1;
                    phase_d  = phase_len;
                end
            end

            S_HOLD: begin
                if (hold_q > HOLD_W'(1)) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d  = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.sw_out    = sw_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;
endmodule
